// File: rtl/pushbutton_conditioner.sv
// Synchronises, debounces and edge-detects active-low board pushbuttons into press pulses.
// Optional auto-repeat while held is enabled by defining PUSHBUTTON_AUTO_REPEAT_EN.
module pushbutton_conditioner #(
    parameter int unsigned NUM_BTN    = 3,
    parameter int unsigned DB_CYCLES  = 1000000,
    parameter int unsigned RPT_DELAY  = 25000000,
    parameter int unsigned RPT_PERIOD = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int unsigned DbW = $clog2(DB_CYCLES);
    localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("DB_CYCLES must be >= 2");
    end
    if (RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_rpt
        $error("RPT_DELAY and RPT_PERIOD must be >= 1");
    end

    logic [NUM_BTN-1:0] meta_q, meta_d;
    logic [NUM_BTN-1:0] sync_q, sync_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] level_prev_q, level_prev_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic [DbW-1:0]     db_cnt_q [NUM_BTN];
    logic [DbW-1:0]     db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] rpt_fire;

    always_comb begin
        meta_d       = btn_raw;
        sync_d       = meta_q;
        pressed      = ~sync_q;
        level_d      = level_q;
        level_prev_d = level_q;
        rise         = level_q & ~level_prev_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = '0;
            if (pressed[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        pulse_d = rise | rpt_fire;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q       <= '1;
            sync_q       <= '1;
            level_q      <= '0;
            level_prev_q <= '0;
            pulse_q      <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            pulse_q      <= pulse_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

`ifdef PUSHBUTTON_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RptW   = (RptMax > 2) ? $clog2(RptMax) : 1;
    localparam logic [RptW-1:0] DelayMax  = RptW'(RPT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodMax = RptW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} rpt_state_e;

    rpt_state_e      rpt_state_q [NUM_BTN];
    rpt_state_e      rpt_state_d [NUM_BTN];
    logic [RptW-1:0] rpt_cnt_q   [NUM_BTN];
    logic [RptW-1:0] rpt_cnt_d   [NUM_BTN];

    // Entry on the same rise that produces the press pulse, so the first repeat lags it.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            unique case (rpt_state_q[i])
                StIdle: begin
                    if (rise[i]) begin
                        rpt_state_d[i] = StHold;
                        rpt_cnt_d[i]   = '0;
                    end
                end
                StHold, StRepeat: begin
                    if (!level_q[i]) begin
                        rpt_state_d[i] = StIdle;
                        rpt_cnt_d[i]   = '0;
                    end else if (rpt_cnt_q[i] ==
                                 ((rpt_state_q[i] == StHold) ? DelayMax : PeriodMax)) begin
                        rpt_fire[i]    = 1'b1;
                        rpt_state_d[i] = StRepeat;
                        rpt_cnt_d[i]   = '0;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    rpt_state_d[i] = StIdle;
                    rpt_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!rst) begin
                rpt_state_q[i] <= StIdle;
                rpt_cnt_q[i]   <= '0;
            end else begin
                rpt_state_q[i] <= rpt_state_d[i];
                rpt_cnt_q[i]   <= rpt_cnt_d[i];
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: doc/pushbutton_conditioner.md
Name: pushbutton_conditioner

Overview:
Input-side front end for the RTC time-setting buttons. It synchronises the raw, active-low, bouncing board pushbuttons and debounces each one independently. It emits a clean single-cycle press pulse per button, which feeds the RTC driver's push_but input. An optional auto-repeat mode lets a held button step minutes or hours continuously.

Parameters:
NUM_BTN, 3, number of independent buttons
DB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 2
RPT_DELAY, 25000000, cycles a press must be held before the first repeat pulse (500 ms); auto-repeat only
RPT_PERIOD, 10000000, cycles between subsequent repeat pulses (200 ms); auto-repeat only

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-low reset
btn_raw  input  NUM_BTN  raw board buttons; 0 = pressed, asynchronous, bouncing
btn_pulse  output  NUM_BTN  1-cycle active-high pulse per accepted press (and per repeat if enabled)
btn_level  output  NUM_BTN  debounced level; 1 = pressed

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst). All state updates on the rising edge of clk.
- Reset (rst=0 at a clk edge):
  - Synchroniser flops set to 1 (released).
  - Debounce counters set to 0.
  - btn_level = 0 and btn_pulse = 0.
  - Repeat FSMs go to IDLE and repeat counters clear.
- Synchroniser: 2-flop chain per bit. sync = ~second flop, so 1 = pressed.
- Debounce, per button, counter width $clog2(DB_CYCLES):
  - sync == btn_level: counter cleared.
  - sync != btn_level and counter < DB_CYCLES-1: counter increments.
  - sync != btn_level and counter == DB_CYCLES-1: btn_level toggles and counter clears.
  - Any glitch shorter than DB_CYCLES cycles clears the count and leaves btn_level unchanged.
- Press pulse:
  - btn_pulse[i] = 1 for exactly one cycle, registered, in the cycle after btn_level[i] goes 0->1.
  - No pulse on release.
- Latency: btn_raw[i] goes low and stays low with the first low sample at edge N.
  - btn_level[i] rises at edge N+1+DB_CYCLES.
  - btn_pulse[i] is high for the cycle following edge N+2+DB_CYCLES.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses; there is no priority or masking.
- Reset mid-operation: all in-flight counts are discarded.
  - A button held through reset deassertion is treated as a new press.
  - It produces one pulse after the full latency measured from the first post-reset edge.
- Counter widths are sized from the parameters; no counter wraps. Each counter saturates at its compare value and clears.

Optional Feature:
- Macro: PUSHBUTTON_AUTO_REPEAT_EN.
- Defined: per-button FSM with states IDLE, HOLD, REPEAT.
  - IDLE -> HOLD on the btn_level rise; the initial press pulse is emitted as normal.
  - HOLD counts to RPT_DELAY-1 while btn_level=1, then emits a pulse and moves to REPEAT.
  - REPEAT emits a pulse every RPT_PERIOD cycles while btn_level=1.
  - btn_level falling in any state -> IDLE, counter cleared, no pulse.
  - A repeat pulse is never coincident with the initial press pulse.
- Undefined: no FSM or repeat counters are synthesised. Exactly one pulse per press; RPT_* parameters are ignored.

Test Plan:
Sim params: NUM_BTN=3, DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=5.
1. Reset: hold rst=0 for 3 cycles with btn_raw=3'b000 -> btn_level=0 and btn_pulse=0 throughout reset. Then rst=1 -> btn_level=3'b111 at edge 6 (first post-reset edge counted as edge 1), with one pulse on all three bits the cycle after.
2. Clean press: btn_raw[0] low from edge 10 -> btn_level[0] rises at edge 15 and btn_pulse[0] is high for exactly one cycle after edge 16. Release -> no pulse; btn_level[0] falls 5 edges after the first high sample.
3. Bounce: btn_raw[1] toggles low/high every 2 cycles for 20 cycles, then holds high -> btn_level[1] stays 0 and btn_pulse[1] never asserts.
4. Simultaneous: btn_raw[2:1] go low on the same edge -> btn_pulse[2] and btn_pulse[1] assert in the same cycle; btn_pulse[0] stays 0.
5. Reset mid-debounce: press btn_raw[0] and assert rst=0 after 2 counted cycles, then release rst with the button still held -> exactly one pulse, at full latency after the first post-reset edge.
6. Auto-repeat (macro defined): hold btn_raw[0] for 40 cycles past btn_level rise -> pulses at offsets +1, +11, +16, +21, +26, +31, +36 cycles. Release -> no further pulses. Macro undefined, same stimulus -> only the +1 pulse.
